// File: rtl/sram_responder_if.sv
// Bus bundle between a CPU core and sram_responder.
// There are two request ports, instruction and data. Each port has a
// request, byte write enables, an address, write data, registered read
// data and a stall flag.
interface sram_responder_if;
    // instruction port
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        req_inst;

    // data port
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        req_data;

    // CPU side: issues requests and sees read data and stalls.
    modport master (
        output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  inst_sram_rdata, req_inst,
        input  data_sram_rdata, req_data
    );

    // Memory side: serves the requests.
    modport slave (
        input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output inst_sram_rdata, req_inst,
        output data_sram_rdata, req_data
    );
endinterface

// File: rtl/sram_responder.sv
// Dual-port (instruction/data) SRAM responder with one shared word array.
// Only one access is in flight at a time. The data port wins arbitration.
// A port that is in its done cycle is not re-arbitrated, so two ports that
// request continuously are served alternately.
// Every access takes WAIT+2 cycles from request to the cycle where req drops.
// WAIT must be in the range 0..7 because it is compared with a 3-bit counter.
module sram_responder #(
    parameter int ADDR_W = 12,
    parameter int WAIT   = 0
) (
    input  logic             clk,
    input  logic             resetn,
    sram_responder_if.slave  bus
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [2:0] WAIT_CNT = 3'(WAIT);
    localparam logic       PORT_I   = 1'b0;
    localparam logic       PORT_D   = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    // Backing store. It is not reset, so its contents survive resetn.
    logic [31:0] mem [0:DEPTH-1];

    state_t      state_reg;
    logic        cur_port_reg;
    logic [2:0]  cnt_reg;
    logic        done_i_reg;
    logic        done_d_reg;
    logic [31:0] inst_rdata_reg;
    logic [31:0] data_rdata_reg;

    logic        pend_i;
    logic        pend_d;
    logic [31:0] acc_addr;
    logic [3:0]  acc_wen;
    logic [31:0] acc_wdata;
    logic [ADDR_W-1:0] acc_idx;
    logic        complete;
    logic        wr_en;
    logic [31:0] rd_word;
    logic [31:0] merged_word;
    logic        unused_addr_bits;

    // A port is pending when it requests and is not in its done cycle.
    assign pend_i = bus.inst_sram_en & ~done_i_reg;
    assign pend_d = bus.data_sram_en & ~done_d_reg;

    // The stall outputs follow the pending terms directly, with no register.
    assign bus.req_inst = pend_i;
    assign bus.req_data = pend_d;

    assign bus.inst_sram_rdata = inst_rdata_reg;
    assign bus.data_sram_rdata = data_rdata_reg;

    // Select the port that owns the access. The live inputs are used at the
    // completion edge, so a port that drops en during ACC still gets served
    // with whatever is present on its inputs at that edge.
    always_comb begin
        acc_addr  = bus.inst_sram_addr;
        acc_wen   = bus.inst_sram_wen;
        acc_wdata = bus.inst_sram_wdata;
        if (cur_port_reg == PORT_D) begin
            acc_addr  = bus.data_sram_addr;
            acc_wen   = bus.data_sram_wen;
            acc_wdata = bus.data_sram_wdata;
        end
    end

    // Word index. The byte offset and the address bits above the array are
    // dropped.
    assign acc_idx = acc_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{acc_addr[1:0], acc_addr[31:ADDR_W+2]};

    assign complete = (state_reg == ACC) && (cnt_reg == WAIT_CNT);
    assign wr_en    = complete && (acc_wen != 4'b0000);
    assign rd_word  = mem[acc_idx];

    // Byte-lane merge: lanes with wen set take the new data, and the other
    // lanes keep the current word.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign merged_word[gi*8 +: 8] = acc_wen[gi] ? acc_wdata[gi*8 +: 8]
                                                    : rd_word[gi*8 +: 8];
    end

    // Array write on the completion edge. Reset forces the FSM to IDLE, so
    // an access cut short by reset never reaches this write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[acc_idx] <= merged_word;
        end
    end

    // Arbitration and access FSM, done pulses and read data registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            cnt_reg        <= 3'd0;
            cur_port_reg   <= PORT_D;
            done_i_reg     <= 1'b0;
            done_d_reg     <= 1'b0;
            inst_rdata_reg <= 32'h0;
            data_rdata_reg <= 32'h0;
        end else begin
            // The done flags last exactly one cycle.
            done_i_reg <= 1'b0;
            done_d_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pend_d) begin
                        state_reg    <= ACC;
                        cur_port_reg <= PORT_D;
                        cnt_reg      <= 3'd0;
                    end else if (pend_i) begin
                        state_reg    <= ACC;
                        cur_port_reg <= PORT_I;
                        cnt_reg      <= 3'd0;
                    end
                end
                ACC: begin
                    if (cnt_reg != WAIT_CNT) begin
                        cnt_reg <= cnt_reg + 3'd1;
                    end else begin
                        state_reg <= IDLE;
                        if (cur_port_reg == PORT_D) begin
                            done_d_reg <= 1'b1;
                            if (acc_wen == 4'b0000) begin
                                data_rdata_reg <= rd_word;
                            end
                        end else begin
                            done_i_reg <= 1'b1;
                            if (acc_wen == 4'b0000) begin
                                inst_rdata_reg <= rd_word;
                            end
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder. It uses two instances, one with WAIT=0 and one
// with WAIT=3. Drivers push the expected completion (cycle and rdata) into a
// queue for each port. A negedge monitor pops and compares the entry each
// time a port shows en high with req low.
module tb_sram_responder;

    logic clk = 1'b0;
    logic rstn0;
    logic rstn3;
    always #5 clk = ~clk;

    sram_responder_if if0();
    sram_responder_if if3();

    sram_responder #(.ADDR_W(12), .WAIT(0)) dut0 (
        .clk    (clk),
        .resetn (rstn0),
        .bus    (if0.slave)
    );

    sram_responder #(.ADDR_W(12), .WAIT(3)) dut3 (
        .clk    (clk),
        .resetn (rstn3),
        .bus    (if3.slave)
    );

    typedef struct {
        int          cycle;
        logic [31:0] data;
    } exp_t;

    // Port keys: 0 = dut0 inst, 1 = dut0 data, 2 = dut3 inst, 3 = dut3 data.
    exp_t q0i[$];
    exp_t q0d[$];
    exp_t q3i[$];
    exp_t q3d[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic push_exp(input int k, input exp_t e);
        case (k)
            0:       q0i.push_back(e);
            1:       q0d.push_back(e);
            2:       q3i.push_back(e);
            default: q3d.push_back(e);
        endcase
    endtask

    task automatic set_port(input int k, input logic en, input logic [3:0] wen,
                            input logic [31:0] addr, input logic [31:0] wdata);
        case (k)
            0: begin
                if0.inst_sram_en = en; if0.inst_sram_wen = wen;
                if0.inst_sram_addr = addr; if0.inst_sram_wdata = wdata;
            end
            1: begin
                if0.data_sram_en = en; if0.data_sram_wen = wen;
                if0.data_sram_addr = addr; if0.data_sram_wdata = wdata;
            end
            2: begin
                if3.inst_sram_en = en; if3.inst_sram_wen = wen;
                if3.inst_sram_addr = addr; if3.inst_sram_wdata = wdata;
            end
            default: begin
                if3.data_sram_en = en; if3.data_sram_wen = wen;
                if3.data_sram_addr = addr; if3.data_sram_wdata = wdata;
            end
        endcase
    endtask

    function automatic logic get_req(input int k);
        case (k)
            0:       return if0.req_inst;
            1:       return if0.req_data;
            2:       return if3.req_inst;
            default: return if3.req_data;
        endcase
    endfunction

    // Scoreboard pop and compare for one observed completion.
    task automatic observe(input int k, input logic [31:0] rdata, input string name);
        exp_t e;
        bit   have;
        have = 1'b0;
        e.cycle = 0;
        e.data  = 32'h0;
        case (k)
            0: if (q0i.size() > 0) begin e = q0i.pop_front(); have = 1'b1; end
            1: if (q0d.size() > 0) begin e = q0d.pop_front(); have = 1'b1; end
            2: if (q3i.size() > 0) begin e = q3i.pop_front(); have = 1'b1; end
            default: if (q3d.size() > 0) begin e = q3d.pop_front(); have = 1'b1; end
        endcase
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL %s: unexpected completion at cycle %0d rdata %h", name, cyc, rdata);
        end else if (e.cycle != cyc || e.data !== rdata) begin
            errors++;
            $display("FAIL %s: completion cycle %0d rdata %h, required cycle %0d rdata %h",
                     name, cyc, rdata, e.cycle, e.data);
        end else begin
            $display("ok   %s: completion cycle %0d rdata %h", name, cyc, rdata);
        end
    endtask

    // Monitor: a completion is the cycle where en is high and req is low.
    always @(negedge clk) begin
        if (if0.inst_sram_en && !if0.req_inst) observe(0, if0.inst_sram_rdata, "d0_inst");
        if (if0.data_sram_en && !if0.req_data) observe(1, if0.data_sram_rdata, "d0_data");
        if (if3.inst_sram_en && !if3.req_inst) observe(2, if3.inst_sram_rdata, "d3_inst");
        if (if3.data_sram_en && !if3.req_data) observe(3, if3.data_sram_rdata, "d3_data");
    end

    // One access. Call it 1 time unit after a rising edge; that cycle is
    // request cycle 0. It returns 1 time unit after the edge that follows the
    // completion cycle, with en dropped.
    task automatic access(input int k, input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input int lat);
        exp_t e;
        int   n;
        e.cycle = cyc + lat;
        e.data  = exp_rdata;
        push_exp(k, e);
        set_port(k, 1'b1, wen, addr, wdata);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (get_req(k) && n < 40);
        if (get_req(k)) begin
            checks++;
            errors++;
            $display("FAIL access_timeout: port %0d req still high after %0d cycles, required low", k, n);
        end
        @(posedge clk); #1;
        set_port(k, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, required finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        exp_t e;
        rstn0 = 1'b0;
        rstn3 = 1'b0;
        for (int k = 0; k < 4; k++) set_port(k, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk); #1;

        // Reset state
        chk("rst_d0_inst_rdata", if0.inst_sram_rdata, 32'h0);
        chk("rst_d0_data_rdata", if0.data_sram_rdata, 32'h0);
        chk("rst_d3_inst_rdata", if3.inst_sram_rdata, 32'h0);
        chk("rst_d3_data_rdata", if3.data_sram_rdata, 32'h0);
        rstn0 = 1'b1;
        rstn3 = 1'b1;
        #1;
        chk("idle_d0_req_inst", {31'h0, if0.req_inst}, 32'h0);
        chk("idle_d0_req_data", {31'h0, if0.req_data}, 32'h0);
        chk("idle_d3_req_inst", {31'h0, if3.req_inst}, 32'h0);
        chk("idle_d3_req_data", {31'h0, if3.req_data}, 32'h0);
        @(posedge clk); #1;

        // WAIT=0: preload word 0x10 and read it back with latency 2
        access(1, 4'hF, 32'h0000_0040, 32'hDEADBEEF, 32'h0000_0000, 2);
        access(1, 4'h0, 32'h0000_0040, 32'h0,        32'hDEADBEEF, 2);

        // Partial byte write over 0xAABBCCDD. rdata keeps the last read value.
        access(1, 4'hF, 32'h0000_0040, 32'hAABBCCDD, 32'hDEADBEEF, 2);
        access(1, 4'h5, 32'h0000_0040, 32'h11223344, 32'hDEADBEEF, 2);
        access(1, 4'h0, 32'h0000_0040, 32'h0,        32'hAA22CC44, 2);

        // Shared array across ports; offset and high address bits are ignored
        access(0, 4'h0, 32'hF000_0042, 32'h0,        32'hAA22CC44, 2);

        // Contention: data finishes in cycle 2, inst in cycle 4
        access(1, 4'hF, 32'h0000_0000, 32'h01020304, 32'hAA22CC44, 2);
        access(1, 4'hF, 32'h0000_0004, 32'h05060708, 32'hAA22CC44, 2);
        fork
            access(0, 4'h0, 32'h0000_0000, 32'h0, 32'h01020304, 4);
            access(1, 4'h0, 32'h0000_0004, 32'h0, 32'h05060708, 2);
        join

        // Continuous contention: completions alternate D, I, D, I
        c0 = cyc;
        for (int k = 0; k < 5; k++) begin
            e.cycle = c0 + 2 + 4 * k; e.data = 32'hAA22CC44; push_exp(1, e);
            e.cycle = c0 + 4 + 4 * k; e.data = 32'h01020304; push_exp(0, e);
        end
        set_port(1, 1'b1, 4'h0, 32'h0000_0040, 32'h0);
        set_port(0, 1'b1, 4'h0, 32'h0000_0000, 32'h0);
        repeat (19) @(posedge clk); #1;
        set_port(1, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk); #1;
        set_port(0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk); #1;

        // WAIT=3: latency 5
        access(3, 4'hF, 32'h0000_0100, 32'h12345678, 32'h0000_0000, 5);
        access(2, 4'h0, 32'h0000_0100, 32'h0,        32'h12345678, 5);
        access(3, 4'h0, 32'h0000_0100, 32'h0,        32'h12345678, 5);

        // Reset during a write in flight: the write is dropped
        set_port(3, 1'b1, 4'hF, 32'h0000_0100, 32'hFFFFFFFF);
        repeat (2) @(posedge clk); #1;
        rstn3 = 1'b0;
        set_port(3, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("arst_d3_req_data",   {31'h0, if3.req_data}, 32'h0);
        chk("arst_d3_req_inst",   {31'h0, if3.req_inst}, 32'h0);
        chk("arst_d3_inst_rdata", if3.inst_sram_rdata, 32'h0);
        chk("arst_d3_data_rdata", if3.data_sram_rdata, 32'h0);
        @(posedge clk); #1;
        rstn3 = 1'b1;
        chk("rel_d3_req_data_en0", {31'h0, if3.req_data}, 32'h0);
        fork
            access(3, 4'h0, 32'h0000_0100, 32'h0, 32'h12345678, 5);
            begin
                #1;
                chk("rel_d3_req_data_en1", {31'h0, if3.req_data}, 32'h1);
            end
        join

        repeat (5) @(posedge clk); #1;
        chk("q0i_drained", 32'(q0i.size()), 32'h0);
        chk("q0d_drained", 32'(q0d.size()), 32'h0);
        chk("q3i_drained", 32'(q3i.size()), 32'h0);
        chk("q3d_drained", 32'(q3d.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter ADDR_W, default 12, word-address bits; backing store is 2^ADDR_W 32-bit words.
REQ-002 Parameter WAIT, default 0, extra wait cycles per access; legal range 0..7.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 inst_sram_en  input  1  instruction-port access request.
REQ-006 inst_sram_wen  input  4  instruction-port byte write enables; 0 means read.
REQ-007 inst_sram_addr  input  32  instruction-port byte address, already translated.
REQ-008 inst_sram_wdata  input  32  instruction-port write data.
REQ-009 inst_sram_rdata  output  32  instruction-port read data, registered.
REQ-010 req_inst  output  1  instruction-port stall; high means the access is not yet complete.
REQ-011 data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata  input  1/4/32/32  data-port request, same meaning as the instruction-port signals.
REQ-012 data_sram_rdata  output  32  data-port read data, registered.
REQ-013 req_data  output  1  data-port stall, same meaning as req_inst.

Function
REQ-014 Word index = addr[ADDR_W+1:2]; addr[1:0] and bits above ADDR_W+1 are ignored.
REQ-015 Single shared array; at most one access is in flight at any time.
REQ-016 FSM states: IDLE, ACC; registers: cur_port (I/D), cnt (3 bits), done_i, done_d.
REQ-017 IDLE, data request pending (data_sram_en & ~done_d): next state ACC, cur_port=D, cnt=0.
REQ-018 IDLE, no data request pending, instruction request pending (inst_sram_en & ~done_i): next state ACC, cur_port=I, cnt=0.
REQ-019 IDLE, both pending: data port wins.
REQ-020 ACC with cnt<WAIT: cnt increments; state unchanged.
REQ-021 ACC with cnt==WAIT, completion edge:
- access performed on cur_port's current addr/wen/wdata;
- done flag of cur_port set;
- next state IDLE.
REQ-022 Completion write: each byte lane k with wen[k]=1 updates; other lanes unchanged; the port's rdata register is unchanged.
REQ-023 Completion read (wen=0): the port's rdata register loads the addressed word; it then holds until that port's next completed read.
REQ-024 done_i and done_d clear on the edge after they set; each is high for exactly one cycle.
REQ-025 req_inst = inst_sram_en & ~done_i; req_data = data_sram_en & ~done_d; both combinational.
REQ-026 Latency: request cycle 0 in IDLE with no contention -> req low and rdata valid in cycle WAIT+2.
REQ-027 A port's done cycle does not re-arbitrate that port; in that cycle the other pending port is granted. This guarantees alternation under continuous contention.
REQ-028 The CPU holds en/addr/wen/wdata stable while req is high. If en drops during ACC, the access still completes using the inputs present at the completion edge.
REQ-029 Read and write of the same word on consecutive accesses: the read returns the newly written data.
REQ-030 en low on both ports: no state change beyond done-flag clearing; both req outputs are 0.

Reset
REQ-031 resetn low asynchronously forces:
- state=IDLE, cnt=0, cur_port=D;
- done_i=done_d=0;
- inst_sram_rdata=data_sram_rdata=0.
REQ-032 Array contents are not reset. An access whose completion edge has not occurred when reset asserts performs no write.
REQ-033 First arbitration happens on the first rising edge with resetn high.

Verification
REQ-034 WAIT=0, data read of word 0x10 preloaded 0xDEADBEEF at cycle 0 -> req_data=1 in cycles 0-1, req_data=0 and data_sram_rdata=0xDEADBEEF in cycle 2.
REQ-035 WAIT=0, data write addr 0x40, wen=4'b0101, wdata=0x11223344 over 0xAABBCCDD, then read 0x40 -> read returns 0xAA22CC44.
REQ-036 WAIT=0, both ports request at cycle 0 (inst read 0x0, data read 0x4) -> data completes with req_data low in cycle 2, inst req_inst low in cycle 4.
REQ-037 WAIT=3, inst read -> req_inst high in cycles 0-4, low in cycle 5 with correct data.
REQ-038 WAIT=3, data write started, resetn pulsed low in cycle 2 -> target word unchanged, all outputs 0, req_data follows data_sram_en after release.
REQ-039 Both ports held continuously requesting for 20 cycles, WAIT=0 -> completions alternate D,I,D,I with no port starved.
